// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - glyph constants, select polarity and FSM states for seven_seg_rx
package seven_seg_pkg;

    // Active-high segment patterns, bit0 = segment a ... bit6 = segment g.
    localparam logic [6:0] GLYPH_0    = 7'h3F;
    localparam logic [6:0] GLYPH_1    = 7'h06;
    localparam logic [6:0] GLYPH_2    = 7'h5B;
    localparam logic [6:0] GLYPH_3    = 7'h4F;
    localparam logic [6:0] GLYPH_4    = 7'h66;
    localparam logic [6:0] GLYPH_5    = 7'h6D;
    localparam logic [6:0] GLYPH_6    = 7'h7D;
    localparam logic [6:0] GLYPH_7    = 7'h07;
    localparam logic [6:0] GLYPH_8    = 7'h7F;
    localparam logic [6:0] GLYPH_9    = 7'h6F;
    localparam logic [6:0] GLYPH_A    = 7'h77;
    localparam logic [6:0] GLYPH_B    = 7'h7C;
    localparam logic [6:0] GLYPH_C    = 7'h39;
    localparam logic [6:0] GLYPH_D    = 7'h5E;
    localparam logic [6:0] GLYPH_E    = 7'h79;
    localparam logic [6:0] GLYPH_F    = 7'h71;
    localparam logic [6:0] GLYPH_DASH = 7'h40;

    // Digit select bit (seg_in[7]) polarity.
    localparam logic SEL_MSB = 1'b0;
    localparam logic SEL_LSB = 1'b1;

    typedef enum logic {
        ST_SYNC    = 1'b0,
        ST_COLLECT = 1'b1
    } rx_state_e;

endpackage

// File: rtl/seven_seg_glyph_dec.sv
// rtl/seven_seg_glyph_dec.sv - combinational active-high glyph to hex nibble lookup
// Ports:
//   pattern_i  7-bit active-high segment pattern (bit0 = a)
//   hit_o      1 when pattern_i is one of the 16 hex glyphs
//   nibble_o   decoded hex value, 0 when hit_o is 0
module seven_seg_glyph_dec
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic       hit_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        hit_o    = 1'b1;
        nibble_o = 4'h0;
        case (pattern_i)
            GLYPH_0:    nibble_o = 4'h0;
            GLYPH_1:    nibble_o = 4'h1;
            GLYPH_2:    nibble_o = 4'h2;
            GLYPH_3:    nibble_o = 4'h3;
            GLYPH_4:    nibble_o = 4'h4;
            GLYPH_5:    nibble_o = 4'h5;
            GLYPH_6:    nibble_o = 4'h6;
            GLYPH_7:    nibble_o = 4'h7;
            GLYPH_8:    nibble_o = 4'h8;
            GLYPH_9:    nibble_o = 4'h9;
            GLYPH_A:    nibble_o = 4'hA;
            GLYPH_B:    nibble_o = 4'hB;
            GLYPH_C:    nibble_o = 4'hC;
            GLYPH_D:    nibble_o = 4'hD;
            GLYPH_E:    nibble_o = 4'hE;
            GLYPH_F:    nibble_o = 4'hF;
            GLYPH_DASH: hit_o    = 1'b0;
            default:    hit_o    = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_rx.sv
// rtl/seven_seg_rx.sv - two-digit seven-segment bus receiver with glitch filter and link timeout
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   seg_in         [6:0] active-low segments a..g, [7] digit select (1 = LSB digit)
//   value          last complete two-digit value {msb, lsb}
//   value_valid    one-cycle pulse when value updates
//   value_changed  one-cycle pulse with value_valid when the new value differs
//   glyph_err      one-cycle pulse when an accepted pattern is not a hex glyph
//   link_lost      level, no accepted glyph within TIMEOUT_CYCLES
module seven_seg_rx
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seg_in,
    output logic [7:0] value,
    output logic       value_valid,
    output logic       value_changed,
    output logic       glyph_err,
    output logic       link_lost
);

    localparam int             TW          = $clog2(TIMEOUT_CYCLES);
    localparam logic [7:0]     STABLE_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0]  TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);

    logic [7:0]    sync1_q, sync2_q, prev_q;
    logic [7:0]    stab_cnt_q, stab_cnt_d;
    logic          accept;
    logic [6:0]    glyph_pat;
    logic          dec_hit;
    logic [3:0]    dec_nibble;

    rx_state_e     state_q, state_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [3:0]    msb_q, msb_d, lsb_q, lsb_d;
    logic          have_msb_q, have_msb_d, have_lsb_q, have_lsb_d;
    logic [7:0]    value_q, value_d;
    logic          valid_q, valid_d, changed_q, changed_d;
    logic          err_q, err_d, lost_q, lost_d;

    // Synchronizer plus one more stage (prev_q) so the filter compares
    // consecutive synchronized samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            stab_cnt_q <= '0;
        end else begin
            sync1_q    <= seg_in;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            stab_cnt_q <= stab_cnt_d;
        end
    end

    always_comb begin
        stab_cnt_d = '0;
        if (sync2_q == prev_q) begin
            stab_cnt_d = (stab_cnt_q == 8'hFF) ? stab_cnt_q : stab_cnt_q + 8'd1;
        end
    end

    // The counter passes through STABLE_LAST exactly once per run because it
    // saturates at 255, above any legal STABLE_CYCLES-1.
    assign accept    = (stab_cnt_q == STABLE_LAST);
    assign glyph_pat = ~prev_q[6:0];

    seven_seg_glyph_dec u_dec (
        .pattern_i (glyph_pat),
        .hit_o     (dec_hit),
        .nibble_o  (dec_nibble)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SYNC;
            tmo_cnt_q  <= '0;
            msb_q      <= '0;
            lsb_q      <= '0;
            have_msb_q <= 1'b0;
            have_lsb_q <= 1'b0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            changed_q  <= 1'b0;
            err_q      <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_cnt_q  <= tmo_cnt_d;
            msb_q      <= msb_d;
            lsb_q      <= lsb_d;
            have_msb_q <= have_msb_d;
            have_lsb_q <= have_lsb_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            changed_q  <= changed_d;
            err_q      <= err_d;
            lost_q     <= lost_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        msb_d      = msb_q;
        lsb_d      = lsb_q;
        have_msb_d = have_msb_q;
        have_lsb_d = have_lsb_q;
        value_d    = value_q;
        valid_d    = 1'b0;
        changed_d  = 1'b0;
        err_d      = 1'b0;
        lost_d     = lost_q;
        tmo_cnt_d  = (tmo_cnt_q == TMO_LAST) ? tmo_cnt_q : tmo_cnt_q + TW'(1);

        // Checked before expiry so a simultaneous accept keeps the link alive.
        if (accept) begin
            tmo_cnt_d = '0;
            if (!dec_hit) begin
                err_d      = 1'b1;
                have_msb_d = 1'b0;
                have_lsb_d = 1'b0;
            end else begin
                state_d = ST_COLLECT;
                lost_d  = 1'b0;
                if (prev_q[7] == SEL_MSB) begin
                    msb_d      = dec_nibble;
                    have_msb_d = 1'b1;
                end
                if (prev_q[7] == SEL_LSB) begin
                    lsb_d      = dec_nibble;
                    have_lsb_d = 1'b1;
                end
                if (have_msb_d && have_lsb_d) begin
                    value_d    = {msb_d, lsb_d};
                    valid_d    = 1'b1;
                    changed_d  = (value_d != value_q);
                    have_msb_d = 1'b0;
                    have_lsb_d = 1'b0;
                end
            end
        end else if (state_q == ST_COLLECT && tmo_cnt_q == TMO_LAST) begin
            state_d    = ST_SYNC;
            lost_d     = 1'b1;
            have_msb_d = 1'b0;
            have_lsb_d = 1'b0;
        end
    end

    assign value         = value_q;
    assign value_valid   = valid_q;
    assign value_changed = changed_q;
    assign glyph_err     = err_q;
    assign link_lost     = lost_q;

endmodule
